// File: rtl/vad_gate_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : vad_gate_reader
//  Purpose  : Read side of the VAD pre-roll ring buffer. On vad_start the read
//             pointer rewinds up to PREROLL samples behind the writer and the
//             block streams buffered history followed by live samples. After
//             vad_end it follows HANGOVER more writer samples and then closes
//             the segment with a last marker.
//  Options  : VAD_GATE_SEG_ID_EN adds a 16-bit segment counter output seg_id.
//  Ports    : clk, rst_n (async, active-low)
//             wr_ptr / wr_fill / sample_valid : writer status
//             vad_start / vad_end             : speech on/off pulses
//             mem_rd_en / mem_rd_addr / mem_rd_data : RAM read port (1-cycle)
//             m_data / m_valid / m_ready / m_first / m_last : output stream
//             active  : segment in progress
//             overrun : sticky, writer lapped the reader
//  Revision : 1.0  initial release
// ============================================================================
module vad_gate_reader #(
    parameter int BUFFER_SIZE = 24000,
    parameter int ADDR_WIDTH  = 15,
    parameter int PREROLL     = 4800,
    parameter int HANGOVER    = 3200
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] wr_ptr,
    input  logic [ADDR_WIDTH-1:0] wr_fill,
    input  logic                  sample_valid,
    input  logic                  vad_start,
    input  logic                  vad_end,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [15:0]           mem_rd_data,
    output logic [15:0]           m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_first,
    output logic                  m_last,
    output logic                  active,
`ifdef VAD_GATE_SEG_ID_EN
    output logic [15:0]           seg_id,
`endif
    output logic                  overrun
);

    localparam int HW = (HANGOVER > 0) ? $clog2(HANGOVER + 1) : 1;

    // Modulo arithmetic is done in ADDR_WIDTH bits: every true result is
    // below BUFFER_SIZE <= 2^ADDR_WIDTH, so wrapping mod 2^ADDR_WIDTH first
    // and adding the ring size back gives the exact ring distance.
    localparam logic [ADDR_WIDTH-1:0] c_size = ADDR_WIDTH'(BUFFER_SIZE);
    localparam logic [ADDR_WIDTH-1:0] c_last = ADDR_WIDTH'(BUFFER_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] c_pre  = ADDR_WIDTH'(PREROLL);
    localparam logic [HW-1:0]         c_hang = HW'(HANGOVER);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_HANG   = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        ptr_inc = (p == c_last) ? '0 : p + 1'b1;
    endfunction

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] stop_ptr_q, stop_ptr_d;
    logic [HW-1:0]         hang_cnt_q, hang_cnt_d;
    logic                  first_pend_q, first_pend_d;
    logic                  last_issued_q, last_issued_d;
    logic                  overrun_q, overrun_d;
    logic                  inflight_q, inflight_d;
    logic                  infl_first_q, infl_first_d;
    logic                  infl_last_q, infl_last_d;
    // FIFO entries: {last, first, data[15:0]}; entry 0 is the head.
    logic [17:0]           fifo0_q, fifo0_d;
    logic [17:0]           fifo1_q, fifo1_d;
    logic [1:0]            fifo_cnt_q, fifo_cnt_d;
    logic [15:0]           seg_id_q, seg_id_d;

    logic [ADDR_WIDTH-1:0] w_pending;
    logic [ADDR_WIDTH-1:0] w_back;
    logic [ADDR_WIDTH-1:0] w_start;
    logic                  w_pop;
    logic [1:0]            w_occupancy;
    logic                  w_read_ok;
    logic                  w_rd_issue;
    logic                  w_rd_last;
    logic                  w_ovr;

    always_comb begin
        w_pending = wr_ptr - rd_ptr_q;
        if (wr_ptr < rd_ptr_q) begin
            w_pending = wr_ptr + c_size - rd_ptr_q;
        end
        w_back  = (c_pre < wr_fill) ? c_pre : wr_fill;
        w_start = wr_ptr - w_back;
        if (wr_ptr < w_back) begin
            w_start = wr_ptr + c_size - w_back;
        end

        w_pop = (fifo_cnt_q != 2'd0) && m_ready;
        // Occupancy counts the slot freed by a pop in this same cycle, so a
        // steady stream keeps one sample in the FIFO and one in the RAM and
        // sustains one sample per clock.
        w_occupancy = fifo_cnt_q - {1'b0, w_pop} + {1'b0, inflight_q};

        w_read_ok = 1'b0;
        case (state_q)
            S_STREAM: w_read_ok = (w_pending != '0);
            // The newest sample is held back until the stop point is known,
            // so that there is always a read left to carry the last tag.
            S_HANG:   w_read_ok = (w_pending > ADDR_WIDTH'(1));
            S_DRAIN:  w_read_ok = (rd_ptr_q != stop_ptr_q) && (w_pending != '0);
            default:  w_read_ok = 1'b0;
        endcase
        w_rd_issue = w_read_ok && (w_occupancy < 2'd2);
        w_rd_last  = (state_q == S_DRAIN) && (ptr_inc(rd_ptr_q) == stop_ptr_q);
        w_ovr      = sample_valid && (state_q != S_IDLE) && (w_pending == c_last);
    end

    always_comb begin
        state_d       = state_q;
        rd_ptr_d      = rd_ptr_q;
        stop_ptr_d    = stop_ptr_q;
        hang_cnt_d    = hang_cnt_q;
        first_pend_d  = first_pend_q;
        last_issued_d = last_issued_q;
        overrun_d     = overrun_q | w_ovr;
        inflight_d    = w_rd_issue;
        infl_first_d  = w_rd_issue & first_pend_q;
        infl_last_d   = w_rd_issue & w_rd_last;
        fifo0_d       = fifo0_q;
        fifo1_d       = fifo1_q;
        fifo_cnt_d    = fifo_cnt_q;
        seg_id_d      = seg_id_q;

        // Read pointer: one step per read, one more when the writer laps us.
        if (w_rd_issue) begin
            rd_ptr_d     = ptr_inc(rd_ptr_d);
            first_pend_d = 1'b0;
            if (w_rd_last) begin
                last_issued_d = 1'b1;
            end
        end
        if (w_ovr) begin
            rd_ptr_d = ptr_inc(rd_ptr_d);
        end

        // Output FIFO: pop shifts the tail forward, then the returning read
        // lands in the first free slot.
        if (w_pop) begin
            fifo0_d    = fifo1_q;
            fifo_cnt_d = fifo_cnt_d - 2'd1;
        end
        if (inflight_q) begin
            if (fifo_cnt_d == 2'd0) begin
                fifo0_d = {infl_last_q, infl_first_q, mem_rd_data};
            end else begin
                fifo1_d = {infl_last_q, infl_first_q, mem_rd_data};
            end
            fifo_cnt_d = fifo_cnt_d + 2'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (vad_start) begin
                    state_d       = S_STREAM;
                    rd_ptr_d      = w_start;
                    first_pend_d  = 1'b1;
                    last_issued_d = 1'b0;
                    seg_id_d      = seg_id_q + 16'd1;
                end
            end
            S_STREAM: begin
                if (vad_end) begin
                    if (HANGOVER == 0) begin
                        stop_ptr_d = wr_ptr;
                        state_d    = S_DRAIN;
                    end else begin
                        hang_cnt_d = c_hang;
                        state_d    = S_HANG;
                    end
                end
            end
            S_HANG: begin
                if (hang_cnt_q == '0) begin
                    stop_ptr_d = wr_ptr;
                    state_d    = S_DRAIN;
                end else if (sample_valid) begin
                    hang_cnt_d = hang_cnt_q - 1'b1;
                end
            end
            S_DRAIN: begin
                if (w_pop && fifo0_q[17]) begin
                    state_d = S_IDLE;
                end else if ((rd_ptr_q == stop_ptr_q) && !last_issued_q &&
                             (fifo_cnt_q == 2'd0) && !inflight_q) begin
                    // Nothing left to tag: close the segment silently once
                    // everything already fetched has been delivered.
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            rd_ptr_q      <= '0;
            stop_ptr_q    <= '0;
            hang_cnt_q    <= '0;
            first_pend_q  <= 1'b0;
            last_issued_q <= 1'b0;
            overrun_q     <= 1'b0;
            inflight_q    <= 1'b0;
            infl_first_q  <= 1'b0;
            infl_last_q   <= 1'b0;
            fifo0_q       <= '0;
            fifo1_q       <= '0;
            fifo_cnt_q    <= '0;
            seg_id_q      <= '0;
        end else begin
            state_q       <= state_d;
            rd_ptr_q      <= rd_ptr_d;
            stop_ptr_q    <= stop_ptr_d;
            hang_cnt_q    <= hang_cnt_d;
            first_pend_q  <= first_pend_d;
            last_issued_q <= last_issued_d;
            overrun_q     <= overrun_d;
            inflight_q    <= inflight_d;
            infl_first_q  <= infl_first_d;
            infl_last_q   <= infl_last_d;
            fifo0_q       <= fifo0_d;
            fifo1_q       <= fifo1_d;
            fifo_cnt_q    <= fifo_cnt_d;
            seg_id_q      <= seg_id_d;
        end
    end

    assign mem_rd_en   = w_rd_issue;
    assign mem_rd_addr = rd_ptr_q;
    assign m_valid     = (fifo_cnt_q != 2'd0);
    assign m_data      = fifo0_q[15:0];
    assign m_first     = m_valid & fifo0_q[16];
    assign m_last      = m_valid & fifo0_q[17];
    assign active      = (state_q != S_IDLE);
    assign overrun     = overrun_q;

`ifdef VAD_GATE_SEG_ID_EN
    assign seg_id = seg_id_q;
`else
    logic w_seg_id_unused;
    assign w_seg_id_unused = ^seg_id_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vad_gate_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_vad_gate_reader
//  Purpose  : Directed bench for vad_gate_reader with a 16-entry ring,
//             PREROLL=4, HANGOVER=2. The writer stores value == address.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vad_gate_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  wr_ptr;
    logic [3:0]  wr_fill;
    logic        sample_valid;
    logic        vad_start;
    logic        vad_end;
    logic        mem_rd_en;
    logic [3:0]  mem_rd_addr;
    logic [15:0] mem_rd_data;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_first;
    logic        m_last;
    logic        active;
    logic        overrun;
`ifdef VAD_GATE_SEG_ID_EN
    logic [15:0] seg_id;
`endif

    logic [15:0] mem [16];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    vad_gate_reader #(
        .BUFFER_SIZE(16),
        .ADDR_WIDTH (4),
        .PREROLL    (4),
        .HANGOVER   (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_ptr      (wr_ptr),
        .wr_fill     (wr_fill),
        .sample_valid(sample_valid),
        .vad_start   (vad_start),
        .vad_end     (vad_end),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_first     (m_first),
        .m_last      (m_last),
        .active      (active),
`ifdef VAD_GATE_SEG_ID_EN
        .seg_id      (seg_id),
`endif
        .overrun     (overrun)
    );

    // Ring RAM: writer stores its own address, read data one cycle later.
    always @(posedge clk) begin
        if (sample_valid) mem[wr_ptr] <= {12'd0, wr_ptr};
        if (mem_rd_en)    mem_rd_data <= mem[mem_rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; the writer pointer advances after an edge that stored.
    // wr_fill saturates at 15, the largest count a 4-bit port can carry.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (sample_valid) begin
            wr_ptr = wr_ptr + 4'd1;
            if (wr_fill != 4'd15) wr_fill = wr_fill + 4'd1;
        end
    endtask

    task automatic write_n(input int n);
        sample_valid = 1'b1;
        repeat (n) cyc();
        sample_valid = 1'b0;
    endtask

    task automatic pulse(input logic s, input logic e);
        vad_start = s;
        vad_end   = e;
        cyc();
        vad_start = 1'b0;
        vad_end   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        vad_start    = 1'b0;
        vad_end      = 1'b0;
        m_ready      = 1'b0;
        wr_ptr       = 4'd0;
        wr_fill      = 4'd0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    // Wait (bounded) for a sample, check it, then accept it with one handshake.
    task automatic expect_out(input string tag, input logic [15:0] d, input logic f, input logic l);
        int w = 0;
        while (m_valid !== 1'b1 && w < 30) begin
            cyc();
            w++;
        end
        check({tag, "_valid"}, 32'(m_valid), 32'd1);
        check({tag, "_data"},  32'(m_data),  32'(d));
        check({tag, "_first"}, 32'(m_first), 32'(f));
        check({tag, "_last"},  32'(m_last),  32'(l));
        m_ready = 1'b1;
        cyc();
        m_ready = 1'b0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        rst_n = 1'b0; sample_valid = 1'b0; vad_start = 1'b0; vad_end = 1'b0;
        m_ready = 1'b0; wr_ptr = 4'd0; wr_fill = 4'd0;
        repeat (2) cyc();
        check("rst_valid",   32'(m_valid),   32'd0);
        check("rst_active",  32'(active),    32'd0);
        check("rst_overrun", 32'(overrun),   32'd0);
        check("rst_rd_en",   32'(mem_rd_en), 32'd0);
        check("rst_first",   32'(m_first),   32'd0);
        check("rst_last",    32'(m_last),    32'd0);
        check("rst_data",    32'(m_data),    32'd0);
        rst_n = 1'b1;
        cyc();

        // ---------------- pre-roll + hangover/last ----------------
        write_n(10);
        pulse(1'b1, 1'b0);
        check("pre_active", 32'(active), 32'd1);
        expect_out("pre_6", 16'd6, 1'b1, 1'b0);
        expect_out("pre_7", 16'd7, 1'b0, 1'b0);
        expect_out("pre_8", 16'd8, 1'b0, 1'b0);
        expect_out("pre_9", 16'd9, 1'b0, 1'b0);
        repeat (3) cyc();
        check("pre_caughtup_valid", 32'(m_valid), 32'd0);
        pulse(1'b0, 1'b1);
        write_n(2);
        expect_out("hang_10", 16'd10, 1'b0, 1'b0);
        expect_out("hang_11", 16'd11, 1'b0, 1'b1);
        check("hang_active_after", 32'(active), 32'd0);

        // ---------------- short history ----------------
        do_reset();
        write_n(2);
        pulse(1'b0, 1'b1);
        check("idle_end_ignored", 32'(active), 32'd0);
        pulse(1'b1, 1'b0);
        expect_out("short_0", 16'd0, 1'b1, 1'b0);
        expect_out("short_1", 16'd1, 1'b0, 1'b0);
        repeat (3) cyc();
        check("short_no_more", 32'(m_valid), 32'd0);
        check("short_active",  32'(active),  32'd1);
        pulse(1'b0, 1'b1);
        write_n(2);
        expect_out("short_2", 16'd2, 1'b0, 1'b0);
        expect_out("short_3", 16'd3, 1'b0, 1'b1);
        check("short_active_after", 32'(active), 32'd0);

        // ---------------- wrap-around, start+end together ----------------
        do_reset();
        write_n(18);
        pulse(1'b1, 1'b1);
        expect_out("wrap_14", 16'd14, 1'b1, 1'b0);
`ifdef VAD_GATE_SEG_ID_EN
        check("seg_id", 32'(seg_id), 32'd1);
`endif
        expect_out("wrap_15", 16'd15, 1'b0, 1'b0);
        expect_out("wrap_0",  16'd0,  1'b0, 1'b0);
        expect_out("wrap_1",  16'd1,  1'b0, 1'b0);
        repeat (3) cyc();
        check("wrap_end_dropped", 32'(active),  32'd1);
        check("wrap_idle_valid",  32'(m_valid), 32'd0);
        pulse(1'b1, 1'b0);

        // ---------------- backpressure ----------------
        write_n(6);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check($sformatf("bp_hold_valid_%0d", i), 32'(m_valid), 32'd1);
            check($sformatf("bp_hold_data_%0d", i),  32'(m_data),  32'd2);
            check($sformatf("bp_hold_first_%0d", i), 32'(m_first), 32'd0);
        end
        for (int i = 0; i < 6; i++) begin
            check($sformatf("bp_nogap_%0d", i), 32'(m_valid), 32'd1);
            expect_out($sformatf("bp_%0d", 2 + i), 16'(2 + i), 1'b0, 1'b0);
        end
        pulse(1'b0, 1'b1);
        write_n(2);
        expect_out("bp_8", 16'd8, 1'b0, 1'b0);
        expect_out("bp_9", 16'd9, 1'b0, 1'b1);
        check("bp_active_after", 32'(active), 32'd0);

        // ---------------- overrun ----------------
        do_reset();
        write_n(8);
        pulse(1'b1, 1'b0);
        repeat (4) cyc();
        write_n(13);
        check("ovr_not_yet", 32'(overrun), 32'd0);
        write_n(1);
        check("ovr_set", 32'(overrun), 32'd1);
        write_n(2);
        check("ovr_hold_data", 32'(m_data), 32'd4);
        // Samples 4 and 5 were fetched before the lap; the reader was then
        // pushed forward to address 9, the oldest it still has unread.
        expect_out("ovr_4",  16'd4,  1'b1, 1'b0);
        expect_out("ovr_5",  16'd5,  1'b0, 1'b0);
        expect_out("ovr_9",  16'd9,  1'b0, 1'b0);
        expect_out("ovr_10", 16'd10, 1'b0, 1'b0);
        check("ovr_sticky", 32'(overrun), 32'd1);

        // ---------------- reset mid-segment ----------------
        rst_n = 1'b0;
        #1;
        check("midrst_active",  32'(active),    32'd0);
        check("midrst_valid",   32'(m_valid),   32'd0);
        check("midrst_overrun", 32'(overrun),   32'd0);
        check("midrst_rd_en",   32'(mem_rd_en), 32'd0);
        do_reset();
        check("midrst_after_valid", 32'(m_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
